scytale_codec: RTL and testbench

- Parametrised scytale engine for both directions. Mode is selected per message: encrypt (0) or decrypt (1).
- Buffers one message of up to MAX_NOF_CHARS characters, terminated by START_TOKEN.
- Checks the message length against key_N*key_M, then streams the permuted characters out.
- Uses valid/ready handshakes on both sides.
- Sits alongside the existing cipher blocks in the decryption/encryption pipeline, between the byte source and the output mux.

---
 rtl/scytale_codec.sv | 182 ++++++++++++++++++
 tb/tb_scytale_codec.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scytale_codec.sv
// Scytale transposition engine: buffers one message, checks its length
// against key_N*key_M, then streams the column/row-permuted characters out.
module scytale_codec #(
  parameter int                 D_WIDTH       = 8,
  parameter int                 KEY_WIDTH     = 8,
  parameter int                 MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0] START_TOKEN   = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 mode_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy,
  output logic                 err_o
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int IW = $clog2(MAX_NOF_CHARS);
  localparam int LW = 2 * KEY_WIDTH;

  typedef enum logic [1:0] {
    LOAD,
    CHECK,
    EMIT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 mode_q, mode_d;
  logic [KEY_WIDTH-1:0] n_q, n_d;
  logic [KEY_WIDTH-1:0] m_q, m_d;
  logic [KEY_WIDTH-1:0] in_q, in_d;
  logic [KEY_WIDTH-1:0] out_q, out_d;
  logic [IW-1:0]        addr_q, addr_d;
  logic                 last_q, last_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];
  logic                 wr_en;
  logic                 take;
  logic [LW-1:0]        len;
  logic [KEY_WIDTH-1:0] in_lim;
  logic [KEY_WIDTH-1:0] stride;

  assign take   = valid_i && ready_q;
  assign len    = LW'(n_q) * LW'(m_q);
  // Encrypt walks down rows (stride M); decrypt walks across (stride N).
  assign in_lim = mode_q ? m_q : n_q;
  assign stride = mode_q ? n_q : m_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    n_d     = n_q;
    m_d     = m_q;
    in_d    = in_q;
    out_d   = out_q;
    addr_d  = addr_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (take) begin
          if (data_i == START_TOKEN) begin
            mode_d  = mode_i;
            n_d     = key_N;
            m_d     = key_M;
            state_d = CHECK;
          end else if (count_q < CW'(MAX_NOF_CHARS)) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (ovf_q || count_q == '0 || n_q == '0 || m_q == '0 ||
            LW'(count_q) != len) begin
          err_d   = 1'b1;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end else begin
          in_d    = '0;
          out_d   = '0;
          addr_d  = '0;
          last_d  = 1'b0;
          valid_d = 1'b0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (valid_q && ready_i && last_q) begin
          valid_d = 1'b0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end else if (!valid_q || ready_i) begin
          data_d  = mem_q[addr_q];
          valid_d = 1'b1;
          last_d  = (in_q == in_lim - 1'b1) && (out_q == stride - 1'b1);
          if (in_q == in_lim - 1'b1) begin
            in_d   = '0;
            out_d  = out_q + 1'b1;
            addr_d = IW'(out_q) + 1'b1;
          end else begin
            in_d   = in_q + 1'b1;
            addr_d = addr_q + IW'(stride);
          end
        end
      end
      default: state_d = LOAD;
    endcase
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      n_q     <= '0;
      m_q     <= '0;
      in_q    <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      m_q     <= m_d;
      in_q    <= in_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[IW-1:0]] <= data_i;
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_scytale_codec.sv
// Bench for scytale_codec: directed messages checked against a
// formula-level transposition model plus literal expectations.
module tb_scytale_codec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       mode_i = 1'b0;
  logic [7:0] key_N = '0;
  logic [7:0] key_M = '0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       busy;
  logic       err_o;

  int         checks = 0;
  int         failures = 0;
  byte        exp_q[$];
  string      cap = "";
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  bit         bp_en = 1'b0;
  int         ph = 0;

  scytale_codec dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .mode_i (mode_i),
    .key_N  (key_N),
    .key_M  (key_M),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy   (busy),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Output k of an N x M row-major block, straight from the cipher definition.
  function automatic string model(string s, int n, int m, bit dec);
    string r = "";
    int idx;
    for (int k = 0; k < n * m; k++) begin
      idx = dec ? (k % m) * n + k / m : (k % n) * m + k / n;
      r = $sformatf("%s%c", r, s[idx]);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(valid_o), 1);
        chk("hold_data", int'(data_o), int'(prev_d));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0h expected none", data_o);
        end else begin
          chk("data_o", int'(data_o), int'(exp_q.pop_front()));
        end
        cap = $sformatf("%s%c", cap, data_o);
      end
      prev_stall = valid_o && !ready_i;
      prev_d = data_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        ready_i = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        ready_i = 1'b1;
      end
    end
  end

  task automatic send_byte(logic [7:0] b);
    int t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ready_wait", int'(ready_o), 1);
    data_i = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic send_msg(string s, int n, int m, bit dec);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    mode_i = dec;
    key_N = 8'(n);
    key_M = 8'(m);
    send_byte(8'hFA);
    key_N = 8'd7;
    key_M = 8'd9;
    mode_i = ~dec;
  endtask

  task automatic run_msg(string s, int n, int m, bit dec, bit ok);
    string e;
    int cyc = 0;
    if (ok) begin
      e = model(s, n, m, dec);
      for (int i = 0; i < e.len(); i++) exp_q.push_back(e[i]);
    end
    send_msg(s, n, m, dec);
    chk("busy_T", int'(busy), 1);
    chk("ready_T", int'(ready_o), 0);
    @(posedge clk);
    #1;
    chk("err_T1", int'(err_o), ok ? 0 : 1);
    chk("valid_T1", int'(valid_o), 0);
    @(posedge clk);
    #1;
    if (!ok) begin
      chk("err_T2", int'(err_o), 0);
      chk("ready_T2", int'(ready_o), 1);
      chk("busy_T2", int'(busy), 0);
      chk("valid_T2", int'(valid_o), 0);
    end else begin
      chk("valid_T2", int'(valid_o), 1);
      while (busy && cyc < 1000) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!bp_en) chk("emit_cycles", cyc, n * m);
      chk("busy_end", int'(busy), 0);
      chk("ready_end", int'(ready_o), 1);
      chk("valid_end", int'(valid_o), 0);
      chk("exp_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    string c1;
    string big;
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_data", int'(data_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(ready_o), 1);

    chk_s("model_enc23", model("ABCDEF", 2, 3, 0), "ADBECF");
    chk_s("model_dec23", model("ADBECF", 2, 3, 1), "ABCDEF");
    chk_s("model_enc32", model("ABCDEF", 3, 2, 0), "ACEBDF");
    chk_s("model_dec32", model("ACEBDF", 3, 2, 1), "ABCDEF");

    cap = "";
    run_msg("ABCDEF", 2, 3, 0, 1);
    chk_s("enc23", cap, "ADBECF");
    cap = "";
    run_msg("ADBECF", 2, 3, 1, 1);
    chk_s("dec23", cap, "ABCDEF");

    cap = "";
    run_msg("ABCDEF", 3, 2, 0, 1);
    c1 = cap;
    chk_s("enc32", c1, "ACEBDF");
    cap = "";
    run_msg(c1, 3, 2, 1, 1);
    chk_s("roundtrip32", cap, "ABCDEF");

    bp_en = 1'b1;
    cap = "";
    run_msg("ADBECF", 2, 3, 1, 1);
    chk_s("dec_bp", cap, "ABCDEF");
    cap = "";
    run_msg("ABCDEFGHIJKL", 3, 4, 0, 1);
    chk_s("enc34_bp", cap, "AEIBFJCGKDHL");
    bp_en = 1'b0;

    run_msg("ABCDE", 2, 3, 0, 0);
    cap = "";
    run_msg("ABCDEF", 2, 3, 0, 1);
    chk_s("after_mismatch", cap, "ADBECF");

    cap = "";
    run_msg("HELLO", 1, 5, 1, 1);
    chk_s("n1_dec", cap, "HELLO");
    cap = "";
    run_msg("HELLO", 5, 1, 0, 1);
    chk_s("m1_enc", cap, "HELLO");

    run_msg("AB", 0, 2, 0, 0);

    big = "";
    for (int i = 0; i < 51; i++) big = $sformatf("%s%c", big, 8'h61 + i % 26);
    run_msg(big, 5, 10, 0, 0);
    big = "";
    for (int i = 0; i < 50; i++) big = $sformatf("%s%c", big, 8'h41 + i % 26);
    cap = "";
    run_msg(big, 5, 10, 1, 1);
    chk_s("full50_dec", cap, model(big, 5, 10, 1));

    e_reset_test : begin
      string e;
      e = model("ABCDEF", 2, 3, 0);
      for (int i = 0; i < e.len(); i++) exp_q.push_back(e[i]);
      send_msg("ABCDEF", 2, 3, 0);
      t = 0;
      while (exp_q.size() > 4 && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("two_out_before_rst", exp_q.size(), 4);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", int'(valid_o), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_data", int'(data_o), 0);
      chk("mid_rst_ready", int'(ready_o), 0);
      exp_q.delete();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_mid_rst", int'(ready_o), 1);
    end

    cap = "";
    run_msg("ADBECF", 2, 3, 1, 1);
    chk_s("after_reset", cap, "ABCDEF");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
